rca_arbiter: RTL and testbench

RCA_ARBITER -- requirements
Module: rca_arbiter

---
 rtl/rca_arbiter.sv | 78 +++++++
 tb/tb_rca_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rca_arbiter.sv
// rca_arbiter: round-robin arbiter sharing one registered ripple-carry adder between two requesters.
// Each granted operation takes four cycles: issue, wait for the adder, capture, respond.
module rca_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_0,
    input  logic [WIDTH-1:0] a_0,
    input  logic [WIDTH-1:0] b_0,
    input  logic             cin_0,
    input  logic             req_1,
    input  logic [WIDTH-1:0] a_1,
    input  logic [WIDTH-1:0] b_1,
    input  logic             cin_1,
    output logic             add_load,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH:0]   add_q,
    output logic             done_0,
    output logic             done_1,
    output logic [WIDTH:0]   result,
    output logic             busy,
    output logic             gnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;
    state_t state;
    logic sel;
    // On a tie, the requester not served last time wins.
    assign sel = (req_0 && req_1) ? ~gnt : req_1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 1'b1;
            add_load <= 1'b0;
            add_a    <= '0;
            add_b    <= '0;
            add_cin  <= 1'b0;
            done_0   <= 1'b0;
            done_1   <= 1'b0;
            result   <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_0 || req_1) begin
                    state    <= ISSUE;
                    gnt      <= sel;
                    busy     <= 1'b1;
                    add_load <= 1'b1;
                    add_a    <= sel ? a_1 : a_0;
                    add_b    <= sel ? b_1 : b_0;
                    add_cin  <= sel ? cin_1 : cin_0;
                end
                ISSUE: begin
                    state    <= CAPT;
                    add_load <= 1'b0;
                    add_a    <= '0;
                    add_b    <= '0;
                    add_cin  <= 1'b0;
                end
                CAPT: begin
                    state  <= RESP;
                    result <= add_q;
                    done_0 <= ~gnt;
                    done_1 <= gnt;
                end
                RESP: begin
                    state  <= IDLE;
                    done_0 <= 1'b0;
                    done_1 <= 1'b0;
                    busy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rca_arbiter.sv
// tb_rca_arbiter: directed and random checks of rca_arbiter against a transaction-timeline model.
// The model records the edge number of each grant and derives every expected output from it.
module tb_rca_arbiter;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic req_0 = 1'b0, req_1 = 1'b0, cin_0 = 1'b0, cin_1 = 1'b0;
    logic [W-1:0] a_0 = '0, b_0 = '0, a_1 = '0, b_1 = '0;
    logic add_load, add_cin, done_0, done_1, busy, gnt;
    logic [W-1:0] add_a, add_b;
    logic [W:0] add_q = '0, result;

    rca_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .a_0(a_0), .b_0(b_0), .cin_0(cin_0),
        .req_1(req_1), .a_1(a_1), .b_1(b_1), .cin_1(cin_1),
        .add_load(add_load), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_q(add_q), .done_0(done_0), .done_1(done_1),
        .result(result), .busy(busy), .gnt(gnt)
    );

    always #5 clk = ~clk;
    // External shared adder: registered sum one clock after the load strobe.
    always @(posedge clk) if (add_load) add_q <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    int checks = 0, failures = 0, cyc = 0;
    int g_edge = -100, g_idx = 0, last_g = 1, free_at = 0;
    int g_a = 0, g_b = 0, g_cin = 0, exp_res = 0;
    bit hold_0 = 0, rnd = 0, prev_ld = 0;
    int d_idx[$], d_cyc[$], d_res[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit ld;
        ld = (cyc == g_edge);
        chk("add_load", add_load, ld);
        chk("add_a", add_a, ld ? g_a : 0);
        chk("add_b", add_b, ld ? g_b : 0);
        chk("add_cin", add_cin, ld ? g_cin : 0);
        chk("done_0", done_0, (cyc == g_edge + 2) && g_idx == 0);
        chk("done_1", done_1, (cyc == g_edge + 2) && g_idx == 1);
        chk("busy", busy, cyc >= g_edge && cyc <= g_edge + 2);
        chk("gnt", gnt, last_g);
        chk("result", result, exp_res);
    endtask

    task automatic tick();
        if (cyc >= free_at && (req_0 || req_1)) begin
            g_idx   = (req_0 && req_1) ? 1 - last_g : (req_1 ? 1 : 0);
            last_g  = g_idx;
            g_edge  = cyc + 1;
            free_at = cyc + 4;
            g_a     = g_idx ? int'(a_1) : int'(a_0);
            g_b     = g_idx ? int'(b_1) : int'(b_0);
            g_cin   = g_idx ? int'(cin_1) : int'(cin_0);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (cyc == g_edge + 2) exp_res = g_a + g_b + g_cin;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        g_edge = -100; free_at = 0; last_g = 1; exp_res = 0; prev_ld = 0;
        check_outputs();
    endtask

    task automatic serve(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("no_b2b_load", add_load & prev_ld, 0);
            prev_ld = add_load;
            if (done_0 || done_1) begin
                d_idx.push_back(int'(done_1)); d_cyc.push_back(cyc); d_res.push_back(int'(result));
            end
            if (rnd) begin
                if (!req_0 && $urandom_range(3) == 0) begin
                    req_0 = 1; a_0 = W'($urandom); b_0 = W'($urandom); cin_0 = 1'($urandom);
                end
                if (!req_1 && $urandom_range(3) == 0) begin
                    req_1 = 1; a_1 = W'($urandom); b_1 = W'($urandom); cin_1 = 1'($urandom);
                end
            end
            if (cyc == g_edge + 2) begin
                if (g_idx == 1) req_1 = 0;
                else if (hold_0) begin
                    a_0 = W'($urandom); b_0 = W'($urandom); cin_0 = 1'($urandom);
                end else req_0 = 0;
            end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        // Single request from requester 0
        req_0 = 1; a_0 = 4'b0001; b_0 = 4'b0101; cin_0 = 0;
        serve(6);
        chk("single_result", result, 5'b00110);
        chk("single_gnt", gnt, 0);
        // Carry-out from requester 1
        req_1 = 1; a_1 = 4'b1111; b_1 = 4'b1111; cin_1 = 0;
        serve(6);
        chk("carry_result", result, 5'b11110);
        chk("carry_gnt", gnt, 1);
        // Tie straight after reset
        do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        d_idx.delete(); d_cyc.delete(); d_res.delete();
        req_0 = 1; a_0 = 4'b1000; b_0 = 4'b0111; cin_0 = 1;
        req_1 = 1; a_1 = 4'b1001; b_1 = 4'b1010; cin_1 = 1;
        serve(10);
        chk("tie_count", d_idx.size(), 2);
        if (d_idx.size() >= 2) begin
            chk("tie_first_idx", d_idx[0], 0);
            chk("tie_first_res", d_res[0], 5'b10000);
            chk("tie_second_idx", d_idx[1], 1);
            chk("tie_second_res", d_res[1], 5'b10100);
            chk("tie_spacing", d_cyc[1] - d_cyc[0], 4);
        end
        // Back-to-back: requester 0 holds its request across transactions
        d_idx.delete(); d_cyc.delete(); d_res.delete();
        hold_0 = 1;
        req_0 = 1; req_1 = 1; a_1 = 4'b0011; b_1 = 4'b0100; cin_1 = 0;
        serve(12);
        hold_0 = 0;
        chk("b2b_count", d_idx.size() >= 3, 1);
        if (d_idx.size() >= 3) begin
            chk("b2b_g0", d_idx[0], 0);
            chk("b2b_g1", d_idx[1], 1);
            chk("b2b_g2", d_idx[2], 0);
        end
        serve(8);
        chk("b2b_drained", req_0 | req_1 | busy, 0);
        // Reset while in CAPT aborts the operation
        req_0 = 1; a_0 = 4'b0110; b_0 = 4'b0011; cin_0 = 1;
        serve(2);
        chk("capt_reached", cyc, g_edge + 1);
        req_0 = 0; req_1 = 1; a_1 = 4'b0111; b_1 = 4'b0001; cin_1 = 0;
        do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        d_idx.delete(); d_cyc.delete(); d_res.delete();
        serve(6);
        chk("rst_served_count", d_idx.size(), 1);
        if (d_idx.size() >= 1) chk("rst_served_idx", d_idx[0], 1);
        chk("rst_result", result, 5'b01000);
        // Late request during ISSUE waits for IDLE
        req_0 = 1; a_0 = 4'b0010; b_0 = 4'b0010; cin_0 = 0;
        tick();
        req_1 = 1; a_1 = 4'b1100; b_1 = 4'b0101; cin_1 = 1;
        prev_ld = add_load;
        serve(10);
        chk("late_result", result, 5'b10010);
        chk("late_gnt", gnt, 1);
        // Random traffic against the model
        rnd = 1;
        serve(400);
        rnd = 0;
        serve(8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
